// File: rtl/claw_pkg.sv
// Shared state encoding and LED bit positions for the claw motion controller.
package claw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FWD   = 2'd1,
    ST_REV   = 2'd2,
    ST_LIMIT = 2'd3
  } axis_state_t;

  localparam int LED_FWD_BIT   = 0;
  localparam int LED_REV_BIT   = 1;
  localparam int LED_LIMIT_BIT = 2;

  function automatic logic is_moving(input axis_state_t s);
    return (s == ST_FWD) || (s == ST_REV);
  endfunction

  function automatic logic [2:0] led_of(input axis_state_t s);
    logic [2:0] v;
    v = 3'b000;
    v[LED_FWD_BIT]   = (s == ST_FWD);
    v[LED_REV_BIT]   = (s == ST_REV);
    v[LED_LIMIT_BIT] = (s == ST_LIMIT);
    return v;
  endfunction

endpackage

// File: rtl/claw_axis_fsm.sv
// One claw axis: IDLE/FWD/REV/LIMIT FSM, optional step timeout, registered decode.
// Timeout logic present only when CLAW_MOVE_TIMEOUT_EN is defined.
module claw_axis_fsm
  import claw_pkg::*;
#(
  parameter int MAX_STEPS = 2000,
  parameter int CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_fwd_press,
  input  logic       i_rev_press,
  input  logic       i_limit,
  input  logic       i_step_tick,
  output logic       o_en,
  output logic       o_dir,
  output logic [2:0] o_led
);

  axis_state_t r_state;
  axis_state_t w_nxt;
  logic        w_timeout;
  logic        r_en;
  logic        r_dir;
  logic [2:0]  r_led;

`ifdef CLAW_MOVE_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;

  assign w_timeout = i_step_tick && (r_cnt == CNT_W'(MAX_STEPS - 1));

  // Count restarts on any transition so each move gets a fresh step budget.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if ((w_nxt != r_state) || !is_moving(r_state)) begin
      r_cnt <= '0;
    end else if (i_step_tick) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  logic [CNT_W-1:0] w_unused_cfg;
  assign w_unused_cfg = CNT_W'(MAX_STEPS) ^ {{(CNT_W-1){1'b0}}, i_step_tick};
  assign w_timeout    = 1'b0;
`endif

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_limit)                         w_nxt = ST_LIMIT;
        else if (i_fwd_press && i_rev_press) w_nxt = ST_IDLE;
        else if (i_fwd_press)                w_nxt = ST_FWD;
        else if (i_rev_press)                w_nxt = ST_REV;
      end
      ST_FWD: begin
        if (i_limit)          w_nxt = ST_LIMIT;
        else if (i_fwd_press) w_nxt = ST_IDLE;
        else if (i_rev_press) w_nxt = ST_REV;
        else if (w_timeout)   w_nxt = ST_IDLE;
      end
      ST_REV: begin
        // A held limit does not stop a reverse move: backing off the stop is allowed.
        if (i_rev_press)      w_nxt = ST_IDLE;
        else if (i_fwd_press) w_nxt = i_limit ? ST_LIMIT : ST_FWD;
        else if (w_timeout)   w_nxt = ST_IDLE;
      end
      ST_LIMIT: begin
        if (i_rev_press)   w_nxt = ST_REV;
        else if (!i_limit) w_nxt = ST_IDLE;
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_en    <= 1'b0;
      r_dir   <= 1'b0;
      r_led   <= 3'b000;
    end else begin
      r_state <= w_nxt;
      r_en    <= is_moving(w_nxt);
      r_led   <= led_of(w_nxt);
      if (w_nxt == ST_FWD)      r_dir <= 1'b1;
      else if (w_nxt == ST_REV) r_dir <= 1'b0;
    end
  end

  assign o_en  = r_en;
  assign o_dir = r_dir;
  assign o_led = r_led;

endmodule

// File: rtl/claw_motion_ctrl.sv
// Two-axis claw motion controller: button edge detect feeding two axis FSMs.
// Optional per-move step timeout enabled by defining CLAW_MOVE_TIMEOUT_EN.
module claw_motion_ctrl
  import claw_pkg::*;
#(
  parameter int MAX_STEPS = 2000,
  parameter int CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step_tick,
  input  logic [3:0] btn,
  input  logic [1:0] limit,
  output logic [1:0] dir,
  output logic [1:0] en,
  output logic [5:0] LED
);

  logic [3:0] r_btn_q;
  logic [3:0] w_press;
  logic [2:0] w_led0;
  logic [2:0] w_led1;

  // All-ones on reset so a button held through reset is not seen as a press.
  always_ff @(posedge clk) begin
    if (rst) r_btn_q <= 4'b1111;
    else     r_btn_q <= btn;
  end

  assign w_press = btn & ~r_btn_q;

  claw_axis_fsm #(
    .MAX_STEPS (MAX_STEPS),
    .CNT_W     (CNT_W)
  ) u_axis0 (
    .clk         (clk),
    .rst         (rst),
    .i_fwd_press (w_press[0]),
    .i_rev_press (w_press[1]),
    .i_limit     (limit[0]),
    .i_step_tick (step_tick),
    .o_en        (en[0]),
    .o_dir       (dir[0]),
    .o_led       (w_led0)
  );

  claw_axis_fsm #(
    .MAX_STEPS (MAX_STEPS),
    .CNT_W     (CNT_W)
  ) u_axis1 (
    .clk         (clk),
    .rst         (rst),
    .i_fwd_press (w_press[2]),
    .i_rev_press (w_press[3]),
    .i_limit     (limit[1]),
    .i_step_tick (step_tick),
    .o_en        (en[1]),
    .o_dir       (dir[1]),
    .o_led       (w_led1)
  );

  assign LED = {w_led1, w_led0};

endmodule

// File: tb/tb_claw_motion_ctrl.sv
// Directed and randomized bench for claw_motion_ctrl with a behavioural reference model.
module tb_claw_motion_ctrl;

  localparam int MS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       step_tick = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic [1:0] limit = 2'b00;
  logic [1:0] dir;
  logic [1:0] en;
  logic [5:0] LED;

  claw_motion_ctrl #(.MAX_STEPS(MS), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .step_tick (step_tick),
    .btn       (btn),
    .limit     (limit),
    .dir       (dir),
    .en        (en),
    .LED       (LED)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

`ifdef CLAW_MOVE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // Reference model: motion modes named by what the claw is doing.
  localparam int M_STOPPED = 0, M_OUT = 1, M_BACK = 2, M_ATSTOP = 3;
  int         m_mode  [2];
  int         m_steps [2];
  bit         m_dir   [2];
  logic [3:0] m_prev_btn;

  function automatic int mode_after(int mode, bit fp, bit rp, bit lim, bit expired);
    if (mode == M_STOPPED) begin
      if (lim) return M_ATSTOP;
      if (fp && rp) return M_STOPPED;
      if (fp) return M_OUT;
      if (rp) return M_BACK;
      return M_STOPPED;
    end
    if (mode == M_OUT) begin
      if (lim) return M_ATSTOP;
      if (fp) return M_STOPPED;
      if (rp) return M_BACK;
      if (expired) return M_STOPPED;
      return M_OUT;
    end
    if (mode == M_BACK) begin
      if (rp) return M_STOPPED;
      if (fp) return lim ? M_ATSTOP : M_OUT;
      if (expired) return M_STOPPED;
      return M_BACK;
    end
    if (rp) return M_BACK;
    if (!lim) return M_STOPPED;
    return M_ATSTOP;
  endfunction

  function automatic logic [2:0] lamp(int mode);
    case (mode)
      M_OUT:    return 3'b001;
      M_BACK:   return 3'b010;
      M_ATSTOP: return 3'b100;
      default:  return 3'b000;
    endcase
  endfunction

  function automatic bit travelling(int mode);
    return (mode == M_OUT) || (mode == M_BACK);
  endfunction

  task automatic model_edge();
    logic [3:0] pr;
    int nm;
    bit expired;
    if (rst) begin
      for (int a = 0; a < 2; a++) begin
        m_mode[a] = M_STOPPED; m_steps[a] = 0; m_dir[a] = 1'b0;
      end
      m_prev_btn = 4'b1111;
      return;
    end
    pr = btn & ~m_prev_btn;
    for (int a = 0; a < 2; a++) begin
      expired = TO_EN && travelling(m_mode[a]) && step_tick && (m_steps[a] + 1 >= MS);
      nm = mode_after(m_mode[a], pr[2*a], pr[2*a+1], limit[a], expired);
      if (nm != m_mode[a] || !travelling(nm)) m_steps[a] = 0;
      else if (step_tick) m_steps[a] = m_steps[a] + 1;
      if (nm == M_OUT) m_dir[a] = 1'b1;
      if (nm == M_BACK) m_dir[a] = 1'b0;
      m_mode[a] = nm;
    end
    m_prev_btn = btn;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      $error("check %s", tag);
    end
  endtask

  // Advance one clock, then compare every output against the model.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("en",  {6'b0, en},  {6'b0, travelling(m_mode[1]), travelling(m_mode[0])});
    check("dir", {6'b0, dir}, {6'b0, m_dir[1], m_dir[0]});
    check("led", {2'b0, LED}, {2'b0, lamp(m_mode[1]), lamp(m_mode[0])});
  endtask

  initial begin
    // Reset state
    rst = 1'b1; step(); step();
    check("rst_en", {6'b0, en}, 8'h00);
    check("rst_led", {2'b0, LED}, 8'h00);
    rst = 1'b0; step();

    // Forward start and stop on axis0
    btn = 4'b0001; step();
    check("fwd_en0", {7'b0, en[0]}, 8'h01);
    check("fwd_dir0", {7'b0, dir[0]}, 8'h01);
    check("fwd_led0", {5'b0, LED[2:0]}, 8'h01);
    btn = 4'b0000; step();
    btn = 4'b0001; step();
    check("stop_en0", {7'b0, en[0]}, 8'h00);

    // Limit hit while moving forward, forward ignored, reverse backs off
    btn = 4'b0000; step();
    btn = 4'b0001; step();
    btn = 4'b0000; limit = 2'b01; step();
    check("lim_en0", {7'b0, en[0]}, 8'h00);
    check("lim_led0", {5'b0, LED[2:0]}, 8'h04);
    btn = 4'b0001; step();
    check("lim_fwd_ign", {7'b0, en[0]}, 8'h00);
    btn = 4'b0000; step();
    btn = 4'b0010; step();
    check("backoff_en0", {7'b0, en[0]}, 8'h01);
    check("backoff_dir0", {7'b0, dir[0]}, 8'h00);
    btn = 4'b0000; step();
    check("rev_lim_hold", {7'b0, en[0]}, 8'h01);
    limit = 2'b00; btn = 4'b0010; step();
    btn = 4'b0000; step();

    // Step timeout on axis1 in reverse
    btn = 4'b1000; step();
    btn = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      step_tick = 1'b1; step();
      step_tick = 1'b0; step();
`ifdef CLAW_MOVE_TIMEOUT_EN
      if (i == 2) check("to_before", {7'b0, en[1]}, 8'h01);
      if (i == 3) check("to_drop", {7'b0, en[1]}, 8'h00);
`endif
    end
`ifndef CLAW_MOVE_TIMEOUT_EN
    check("no_to_en1", {7'b0, en[1]}, 8'h01);
`endif
    rst = 1'b1; step();
    rst = 1'b0; step();

    // Simultaneous fwd+rev presses on axis1
    btn = 4'b1100; step();
    check("both_idle_en1", {7'b0, en[1]}, 8'h00);
    check("both_idle_led1", {5'b0, LED[5:3]}, 8'h00);
    btn = 4'b0000; step();
    btn = 4'b0100; step();
    check("ax1_fwd", {7'b0, en[1]}, 8'h01);
    btn = 4'b0000; step();
    btn = 4'b1100; step();
    check("both_fwd_en1", {7'b0, en[1]}, 8'h00);
    check("both_fwd_led1", {5'b0, LED[5:3]}, 8'h00);

    // Button held through reset release
    btn = 4'b0001; rst = 1'b1; step();
    rst = 1'b0; step(); step();
    check("held_no_move", {7'b0, en[0]}, 8'h00);
    btn = 4'b0000; step();
    btn = 4'b0001; step();
    check("held_then_fwd", {7'b0, en[0]}, 8'h01);
    check("held_then_dir", {7'b0, dir[0]}, 8'h01);

    // Reset pulse aborts both axes mid-move
    btn = 4'b0000; step();
    btn = 4'b1000; step();
    check("both_move", {6'b0, en}, 8'h03);
    btn = 4'b0000; rst = 1'b1; step();
    check("abort_en", {6'b0, en}, 8'h00);
    check("abort_dir", {6'b0, dir}, 8'h00);
    check("abort_led", {2'b0, LED}, 8'h00);
    rst = 1'b0;

    // Limits asserted at reset release go straight to the end-stop state
    limit = 2'b11; rst = 1'b1; step();
    rst = 1'b0; step();
    check("post_rst_lim", {2'b0, LED}, 8'h24);
    limit = 2'b00; step();

    // Randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) btn = 4'($urandom);
      if ($urandom_range(0, 15) == 0) limit = 2'($urandom);
      step_tick = 1'($urandom);
      rst = ($urandom_range(0, 79) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
